return_addr_stack: RTL and testbench
====================================

// Module: return_addr_stack
// PURPOSE
//  Parametrised hardware return-address stack for the single-cycle MIPS core.
//  Generalises the jal/jalm link: keeps up to DEPTH return addresses instead of one link value.
//  IFU pushes PC+4 on jal/jalr/jalm and pops on jr $ra.
//  Exposes the predicted return target and occupancy status.
//  Sits beside the IFU; jalm still writes its link to dmemory independently.
// PARAMETERS
//  WIDTH            32  bits per stored return address
//  DEPTH            8   entries; power of two, >=2
//  OVERWRITE_OLDEST 1   1: push when full discards oldest (circular); 0: push when full is rejected
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous active-low reset
//  push       in   1            push push_addr this cycle
//  push_addr  in   WIDTH        return address to store (PC+4)
//  pop        in   1            pop top entry this cycle
//  flush      in   1            discard all entries (pipeline/exception redirect)
//  top_addr   out  WIDTH        current top entry; 0 when empty
//  top_valid  out  1            stack non-empty
//  full       out  1            count == DEPTH
//  count      out  clog2(DEPTH)+1 occupancy
//  overflow   out  1            sticky: push lost data (oldest dropped or push rejected)
//  underflow  out  1            sticky: pop while empty
// BEHAVIOUR
//  - Reset (rst_n=0, async): count=0, pointer=0, top_addr=0, top_valid=0, full=0,
//    overflow=0, underflow=0; storage contents don't-care but never visible.
//  - top_addr/top_valid/full/count are combinational from registered state (0-cycle read);
//    updates from push/pop take effect at the next rising clk.
//  - Storage: circular array, top pointer tp (log2 DEPTH bits, wraps mod DEPTH).
//  - push only: tp<=tp+1; mem[tp+1]<=push_addr; count<=min(count+1,DEPTH).
//      full & OVERWRITE_OLDEST=1: write proceeds, count stays DEPTH, oldest overwritten, overflow<=1.
//      full & OVERWRITE_OLDEST=0: no state change, overflow<=1.
//  - pop only: count>0 -> tp<=tp-1, count<=count-1.
//      count==0 -> no change, underflow<=1.
//  - push & pop same cycle: replace top, mem[tp]<=push_addr; tp and count unchanged.
//      If empty: acts as push only; underflow not set.
//  - flush: highest priority; count<=0, tp<=0; push/pop that cycle ignored.
//      Sticky flags are not cleared by flush; only rst_n clears them.
//  - Wrap-around: tp increments DEPTH-1 -> 0 and decrements 0 -> DEPTH-1 without disturbing
//    valid entries.
//  - Reset asserted mid-operation: all state returns to reset values immediately, regardless of clk.
//  - No X on outputs after reset even if push_addr carries X while push=0.
// TESTING
//  1. reset, push 0x4 then 0xC, pop once -> top_addr=0x4, count=1 (jalm-style link round trip).
//  2. push DEPTH=8 values 0x10..0x2C (step 4) -> full=1, count=8, top_addr=0x2C, overflow=0.
//  3. OVERWRITE_OLDEST=1, 9th push 0x30, 8 pops -> tops 0x30..0x14 in order, count=0,
//     overflow=1; 0x10 lost.
//  4. OVERWRITE_OLDEST=0, 9th push 0x30 when full -> top_addr=0x2C, count=8, overflow=1.
//  5. push 0x4, then push&pop 0x1D same cycle -> top_addr=0x1D, count=1;
//     pop on empty -> underflow=1, count=0.
//  6. push 3 entries, flush with push=1 -> count=0, top_valid=0, top_addr=0;
//     rst_n low mid-burst -> all outputs 0 before next clk.

Source files
------------

// File: rtl/return_addr_stack_if.sv
// Bundles the push/pop/flush requests and the occupancy/status outputs of the return-address stack.
// The master side is the IFU (or the bench). The slave side is the stack itself.
interface return_addr_stack_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic [WIDTH-1:0] push_addr;
  logic             pop;
  logic             flush;
  logic [WIDTH-1:0] top_addr;
  logic             top_valid;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, push_addr, pop, flush,
    input  top_addr, top_valid, full, count, overflow, underflow
  );

  modport slave (
    input  push, push_addr, pop, flush,
    output top_addr, top_valid, full, count, overflow, underflow
  );
endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack: PC+4 is pushed on jal/jalr/jalm and popped on jr $ra.
// It predicts the return target and reports occupancy plus sticky overflow/underflow flags.
module return_addr_stack #(
  parameter int WIDTH            = 32,
  parameter int DEPTH            = 8,
  parameter int OVERWRITE_OLDEST = 1
) (
  input logic               clk,
  input logic               rst_n,
  return_addr_stack_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    tp_q, tp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic             full_w, empty_w;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = tp_q;
    if (bus.flush) begin
      tp_d    = '0;
      count_d = '0;
    end else if (bus.push && bus.pop && !empty_w) begin
      // Simultaneous call and return replaces the top entry in place.
      wr_en  = 1'b1;
      wr_idx = tp_q;
    end else if (bus.push) begin
      if (!full_w) begin
        tp_d    = tp_q + PW'(1);
        count_d = count_q + CW'(1);
        wr_en   = 1'b1;
        wr_idx  = tp_q + PW'(1);
      end else begin
        ovf_d = 1'b1;
        if (OVERWRITE_OLDEST != 0) begin
          // When full, the slot above the top holds the oldest entry, so the new write drops it.
          tp_d   = tp_q + PW'(1);
          wr_en  = 1'b1;
          wr_idx = tp_q + PW'(1);
        end
      end
    end else if (bus.pop) begin
      if (empty_w) begin
        unf_d = 1'b1;
      end else begin
        tp_d    = tp_q - PW'(1);
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage needs no reset: an entry is only ever visible after it has been written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= bus.push_addr;
  end

  assign bus.top_addr  = empty_w ? '0 : mem_q[tp_q];
  assign bus.top_valid = !empty_w;
  assign bus.full      = full_w;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_return_addr_stack.sv
// Drives two stacks with the same stimulus: one overwrites the oldest entry when full, the other rejects the push.
// Both are checked against a shifting-array model, a vector table and hand-written corner sequences.
module tb_return_addr_stack;
  localparam int W = 32;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  return_addr_stack_if #(.WIDTH(W), .DEPTH(D)) bus_a ();
  return_addr_stack_if #(.WIDTH(W), .DEPTH(D)) bus_b ();

  return_addr_stack #(.WIDTH(W), .DEPTH(D), .OVERWRITE_OLDEST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  return_addr_stack #(.WIDTH(W), .DEPTH(D), .OVERWRITE_OLDEST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  int total = 0;
  int bad   = 0;

  // Model: index 0 is the oldest entry and index msz-1 is the top. Dropping the oldest shifts everything down.
  logic [W-1:0] mdl [2][D];
  int           msz  [2];
  bit           movf [2];
  bit           munf [2];

  typedef struct {
    bit           push, pop, flush;
    logic [W-1:0] addr;
    logic [W-1:0] top;
    bit           valid;
    int           cnt;
    bit           full, ovf, unf;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      msz[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0;
    end
  endtask

  task automatic model_step(int k, bit ow, bit p, bit po, bit f, logic [W-1:0] a);
    if (f) msz[k] = 0;
    else if (p && po && msz[k] > 0) mdl[k][msz[k]-1] = a;
    else if (p) begin
      if (msz[k] < D) begin
        mdl[k][msz[k]] = a;
        msz[k]++;
      end else begin
        movf[k] = 1'b1;
        if (ow) begin
          for (int i = 0; i < D - 1; i++) mdl[k][i] = mdl[k][i+1];
          mdl[k][D-1] = a;
        end
      end
    end else if (po) begin
      if (msz[k] == 0) munf[k] = 1'b1;
      else msz[k]--;
    end
  endtask

  task automatic check_model();
    logic [W-1:0] et;
    for (int k = 0; k < 2; k++) begin
      et = (msz[k] > 0) ? mdl[k][msz[k]-1] : '0;
      if (k == 0) begin
        chk("a_top",   64'(bus_a.top_addr),  64'(et));
        chk("a_valid", 64'(bus_a.top_valid), 64'(msz[k] > 0));
        chk("a_count", 64'(bus_a.count),     64'(msz[k]));
        chk("a_full",  64'(bus_a.full),      64'(msz[k] == D));
        chk("a_ovf",   64'(bus_a.overflow),  64'(movf[k]));
        chk("a_unf",   64'(bus_a.underflow), 64'(munf[k]));
      end else begin
        chk("b_top",   64'(bus_b.top_addr),  64'(et));
        chk("b_valid", 64'(bus_b.top_valid), 64'(msz[k] > 0));
        chk("b_count", 64'(bus_b.count),     64'(msz[k]));
        chk("b_full",  64'(bus_b.full),      64'(msz[k] == D));
        chk("b_ovf",   64'(bus_b.overflow),  64'(movf[k]));
        chk("b_unf",   64'(bus_b.underflow), 64'(munf[k]));
      end
    end
  endtask

  task automatic drive(bit p, bit po, bit f, logic [W-1:0] a);
    bus_a.push = p; bus_a.pop = po; bus_a.flush = f; bus_a.push_addr = a;
    bus_b.push = p; bus_b.pop = po; bus_b.flush = f; bus_b.push_addr = a;
  endtask

  task automatic step(bit p, bit po, bit f, logic [W-1:0] a);
    drive(p, po, f, a);
    @(posedge clk);
    #1;
    model_step(0, 1'b1, p, po, f, a);
    model_step(1, 1'b0, p, po, f, a);
    check_model();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    model_reset();
    #12;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic void add(bit p, bit po, bit f, logic [W-1:0] a, logic [W-1:0] t,
                              bit vld, int c, bit fu, bit o, bit u);
    vec_t r;
    r.push = p; r.pop = po; r.flush = f; r.addr = a; r.top = t;
    r.valid = vld; r.cnt = c; r.full = fu; r.ovf = o; r.unf = u;
    tbl.push_back(r);
  endfunction

  initial begin
    bit p, po, f;
    logic [W-1:0] a;

    // Vectors describe the overwrite-oldest stack, applied in order from reset.
    add(1,0,0,32'h4,  32'h4, 1,1,0,0,0);
    add(1,0,0,32'hC,  32'hC, 1,2,0,0,0);
    add(0,1,0,32'h0,  32'h4, 1,1,0,0,0);
    add(0,1,0,32'h0,  32'h0, 0,0,0,0,0);
    add(1,1,0,32'h8,  32'h8, 1,1,0,0,0);
    add(0,1,0,32'h0,  32'h0, 0,0,0,0,0);
    for (int i = 0; i < 8; i++)
      add(1,0,0, 32'h10 + 32'(4*i), 32'h10 + 32'(4*i), 1, i+1, i == 7, 0, 0);
    add(1,0,0,32'h30, 32'h30,1,8,1,1,0);
    for (int k = 1; k <= 8; k++)
      add(0,1,0,32'h0, (k < 8) ? 32'h30 - 32'(4*k) : 32'h0, k < 8, 8-k, 0, 1, 0);
    add(1,0,0,32'h4,  32'h4, 1,1,0,1,0);
    add(1,1,0,32'h1D, 32'h1D,1,1,0,1,0);
    add(0,1,0,32'h0,  32'h0, 0,0,0,1,0);
    add(0,1,0,32'h0,  32'h0, 0,0,0,1,1);
    add(1,0,0,32'h100,32'h100,1,1,0,1,1);
    add(1,0,0,32'h104,32'h104,1,2,0,1,1);
    add(1,0,0,32'h108,32'h108,1,3,0,1,1);
    add(1,0,1,32'h200,32'h0, 0,0,0,1,1);
    add(1,0,0,32'h44, 32'h44,1,1,0,1,1);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].push, tbl[i].pop, tbl[i].flush, tbl[i].addr);
      chk($sformatf("v%0d_top", i),   64'(bus_a.top_addr),  64'(tbl[i].top));
      chk($sformatf("v%0d_valid", i), 64'(bus_a.top_valid), 64'(tbl[i].valid));
      chk($sformatf("v%0d_count", i), 64'(bus_a.count),     64'(tbl[i].cnt));
      chk($sformatf("v%0d_full", i),  64'(bus_a.full),      64'(tbl[i].full));
      chk($sformatf("v%0d_ovf", i),   64'(bus_a.overflow),  64'(tbl[i].ovf));
      chk($sformatf("v%0d_unf", i),   64'(bus_a.underflow), 64'(tbl[i].unf));
    end

    // The rejecting stack keeps its top when a ninth push arrives while it is full.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h10 + 32'(4*i));
    step(1'b1, 1'b0, 1'b0, 32'h30);
    chk("rej_top",   64'(bus_b.top_addr), 64'h2C);
    chk("rej_count", 64'(bus_b.count),    64'd8);
    chk("rej_ovf",   64'(bus_b.overflow), 64'd1);
    chk("ow_top",    64'(bus_a.top_addr), 64'h30);

    // An asynchronous reset in the middle of a burst clears every output before the next clock edge.
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 32'hA0);
    step(1'b1, 1'b0, 1'b0, 32'hA4);
    drive(1'b1, 1'b0, 1'b0, 32'hA8);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_top",   64'(bus_a.top_addr),  64'h0);
    chk("mid_rst_count", 64'(bus_a.count),     64'h0);
    chk("mid_rst_valid", 64'(bus_a.top_valid), 64'h0);
    chk("mid_rst_ovf",   64'(bus_b.overflow),  64'h0);
    chk("mid_rst_unf",   64'(bus_a.underflow), 64'h0);
    model_reset();
    drive(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic exercises pointer wrap-around in both directions.
    for (int n = 0; n < 3000; n++) begin
      p  = ($urandom_range(0, 9) < 5);
      po = ($urandom_range(0, 9) < 4);
      f  = ($urandom_range(0, 63) == 0);
      a  = p ? W'($urandom) : W'(0);
      step(p, po, f, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
